// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core memory stage and a
// byte-lane data RAM with one-cycle registered read data.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_we, req_size,          store flag, size (00 B, 01 H, 10 W, 11 illegal),
//   req_unsigned               zero-extend for byte/half loads
//   req_addr, req_wdata        byte address, right-aligned store data
//   ram_we, ram_mem_ctrl,      RAM write strobe, store width code,
//   ram_addr, ram_wdata        byte address, write data (unshifted)
//   ram_rdata                  RAM read word, valid one cycle after ram_addr
//   rsp_valid, rsp_err,        one-cycle completion pulse, error flag,
//   rsp_rdata                  extended load result
//
// Misaligned loads (half at offset 3, word at offset != 0) are split into
// two word reads; misaligned stores, illegal sizes and accesses beyond
// MEM_BYTES complete immediately with rsp_err.

// Output byte LANE of the load result: byte (LANE + off) of the {w1,w0}
// window, i.e. one lane of a right shift by 8*off.
module lsu_byte_sel #(
    parameter int LANE = 0
) (
    input  logic [7:0][7:0] win,
    input  logic [1:0]      off,
    output logic [7:0]      b
);
    logic [2:0] idx;
    assign idx = 3'(LANE) + {1'b0, off};
    assign b   = win[idx];
endmodule

module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ram_we,
    output logic [1:0]  ram_mem_ctrl,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata
);
    localparam int          NUM_LANES = 4;
    localparam logic [31:0] MEM_LIM   = MEM_BYTES;

    // RAM store width codes
    localparam logic [1:0] STORE_B  = 2'b00;
    localparam logic [1:0] STORE_HW = 2'b01;
    localparam logic [1:0] STORE_W  = 2'b10;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_ISSUE2 = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
    } req_t;

    logic [2:0]  state;
    req_t        req_q;
    logic        split_q;
    logic [31:0] w0;

    // ---------------- incoming request decode ----------------
    logic        accept;
    logic [1:0]  off_in;
    logic        mis_in;
    logic [31:0] addr2_in;
    logic        err_in;
    logic [1:0]  ctrl_in;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign off_in    = req_addr[1:0];
    assign mis_in    = ((req_size == SZ_H) && (off_in == 2'd3)) ||
                       ((req_size == SZ_W) && (off_in != 2'd0));
    // Second word of a split load; wraps mod 2^32, still range-checked.
    assign addr2_in  = {req_addr[31:2], 2'b00} + 32'd4;
    assign err_in    = (req_size == SZ_ILL) ||
                       (req_we && mis_in) ||
                       (req_addr >= MEM_LIM) ||
                       (!req_we && mis_in && (addr2_in >= MEM_LIM));

    always_comb begin
        ctrl_in = STORE_W;
        if (req_we) begin
            case (req_size)
                SZ_B:    ctrl_in = STORE_B;
                SZ_H:    ctrl_in = STORE_HW;
                default: ctrl_in = STORE_W;
            endcase
        end
    end

    // ---------------- load extract ----------------
    // In WAIT the live RAM word is w0 (aligned) or w1 (split).
    logic [31:0]               lo_w, hi_w, ld_data;
    logic [7:0][7:0]           win;
    logic [NUM_LANES-1:0][7:0] v;

    assign lo_w = split_q ? w0 : ram_rdata;
    assign hi_w = split_q ? ram_rdata : 32'd0;
    assign win  = {hi_w, lo_w};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            lsu_byte_sel #(.LANE(g)) u_sel (
                .win (win),
                .off (req_q.addr[1:0]),
                .b   (v[g])
            );
        end
    endgenerate

    always_comb begin
        ld_data = v;
        case (req_q.size)
            SZ_B:    ld_data = {{24{~req_q.uns & v[0][7]}}, v[0]};
            SZ_H:    ld_data = {{16{~req_q.uns & v[1][7]}}, v[1], v[0]};
            default: ld_data = v;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_q        <= '0;
            split_q      <= 1'b0;
            w0           <= 32'd0;
            ram_we       <= 1'b0;
            ram_mem_ctrl <= STORE_W;
            ram_addr     <= 32'd0;
            ram_wdata    <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'd0;
        end else begin
            // single-cycle strobes
            ram_we    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_q   <= '{we: req_we, size: req_size,
                                     uns: req_unsigned, addr: req_addr};
                        split_q <= !req_we && mis_in;
                        if (err_in) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state        <= S_ISSUE;
                            ram_addr     <= req_addr;
                            ram_we       <= req_we;
                            ram_mem_ctrl <= ctrl_in;
                            if (req_we)
                                ram_wdata <= req_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_q.we) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end else if (split_q) begin
                        state    <= S_ISSUE2;
                        ram_addr <= {req_q.addr[31:2], 2'b00} + 32'd4;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_ISSUE2: begin
                    w0    <= ram_rdata;   // first word of the split pair
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_data;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
